// File: rtl/fir_host_if_if.sv
// Host register bus for the FIR host front end.
//   wr_en/wr_addr/wr_data : single-cycle write strobe with address and data
//   rd_en/rd_addr         : single-cycle read strobe with address
//   rd_data               : read data, registered, valid the cycle after rd_en
// master = bus host, slave = fir_host_if.
interface fir_host_if_if;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data
  );
endinterface

// File: rtl/fir_host_if.sv
// Host-side front end for the FIR filter core.
// Turns host register writes/reads into the core's dr/lc handshake, buffers
// one pending sample, sequences the four coefficient loads, and captures each
// filtered result.
//
// Ports:
//   clk, n_reset   : clock (rising edge), asynchronous active-low reset
//   bus            : host register bus (slave side)
//   modwait, err   : core busy / core error, from the FIR controller
//   fir_out        : datapath result register
//   dr, lc         : data ready / load coefficient to the core
//   sample_data    : sample presented to the datapath
//   fir_coeff      : coefficient presented to the datapath
//   result_valid   : unread result present (interrupt level)
//   state_dbg      : current FSM state encoding
//
// Core handshake: the front end raises dr (2 or 3 cycles) or lc (1 cycle) to
// hand work to the core, then treats the first cycle with modwait=0 as the
// core having finished that piece of work; err is sampled in that same cycle.
//
// Write map: 0 sample, 1..4 coef[0..3], 5 bit0=1 requests coefficient load,
//            6 clears err_flag and overrun, 7 ignored.
// Read map:  0 result (clears result_valid), 1 status, 2..5 coef[0..3],
//            6..7 zero.
module fir_host_if (
  input  logic             clk,
  input  logic             n_reset,
  fir_host_if_if.slave     bus,
  input  logic             modwait,
  input  logic             err,
  input  logic [15:0]      fir_out,
  output logic             dr,
  output logic             lc,
  output logic [15:0]      sample_data,
  output logic [15:0]      fir_coeff,
  output logic             result_valid,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DR       = 3'd1,
    S_CALC     = 3'd2,
    S_LC_PULSE = 3'd3,
    S_LC_BUSY  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] coef [4];
  logic [15:0] pend_data;
  logic [15:0] result;
  logic        pend_full;
  logic        load_req;
  logic        err_flag;
  logic        overrun;
  logic        dr_ext;
  logic [1:0]  idx;
  logic [1:0]  dr_cnt;

  logic        samp_wr;
  logic        load_go;
  logic        pop;
  logic        direct;
  logic        advance;
  logic        capture_ok;
  logic        capture_err;
  logic        loading;
  logic        busy;
  logic [15:0] status;
  logic [15:0] rd_mux;

  // Next state and handshake decode
  always_comb begin
    state_nxt = state;
    load_go   = 1'b0;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (load_req && !err) begin
          load_go   = 1'b1;
          state_nxt = S_LC_PULSE;
        end else if (pend_full) begin
          pop       = 1'b1;
          state_nxt = S_DR;
        end else if (samp_wr) begin
          state_nxt = S_DR;
        end
      end
      // The hold is stretched by one cycle when the core was in its error
      // idle state during the first dr cycle.
      S_DR: begin
        if ((dr_cnt == 2'd1 && !dr_ext) || dr_cnt == 2'd2) state_nxt = S_CALC;
      end
      S_CALC: begin
        if (!modwait) state_nxt = S_IDLE;
      end
      S_LC_PULSE: state_nxt = S_LC_BUSY;
      S_LC_BUSY: begin
        if (!modwait) state_nxt = (idx == 2'd3) ? S_IDLE : S_LC_PULSE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign samp_wr     = bus.wr_en && (bus.wr_addr == 3'd0);
  // A sample goes straight to the datapath only when nothing else is about
  // to start; otherwise it lands in the pending slot.
  assign direct      = samp_wr && (state == S_IDLE) && !load_go && !pend_full;
  assign advance     = (state == S_LC_BUSY) && !modwait && (idx != 2'd3);
  assign capture_ok  = (state == S_CALC) && !modwait && !err;
  assign capture_err = (state == S_CALC) && !modwait && err;
  assign loading     = (state == S_LC_PULSE) || (state == S_LC_BUSY);
  assign busy        = (state != S_IDLE) || pend_full;
  assign status      = {11'b0, overrun, load_req | loading, err_flag, result_valid, busy};
  assign dr          = (state == S_DR);
  assign lc          = (state == S_LC_PULSE);
  assign state_dbg   = state;

  always_comb begin
    rd_mux = 16'h0000;
    case (bus.rd_addr)
      3'd0:    rd_mux = result;
      3'd1:    rd_mux = status;
      3'd2:    rd_mux = coef[0];
      3'd3:    rd_mux = coef[1];
      3'd4:    rd_mux = coef[2];
      3'd5:    rd_mux = coef[3];
      default: rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= S_IDLE;
      for (int i = 0; i < 4; i++) coef[i] <= 16'h0000;
      pend_data    <= 16'h0000;
      pend_full    <= 1'b0;
      sample_data  <= 16'h0000;
      fir_coeff    <= 16'h0000;
      result       <= 16'h0000;
      result_valid <= 1'b0;
      load_req     <= 1'b0;
      err_flag     <= 1'b0;
      overrun      <= 1'b0;
      dr_ext       <= 1'b0;
      idx          <= 2'd0;
      dr_cnt       <= 2'd0;
      bus.rd_data  <= 16'h0000;
    end else begin
      state <= state_nxt;

      // Register writes
      if (bus.wr_en) begin
        case (bus.wr_addr)
          3'd1: coef[0] <= bus.wr_data;
          3'd2: coef[1] <= bus.wr_data;
          3'd3: coef[2] <= bus.wr_data;
          3'd4: coef[3] <= bus.wr_data;
          default: ;
        endcase
      end

      // Load request: a new request written in the same cycle it is
      // consumed survives and runs another load later.
      if (load_go) load_req <= 1'b0;
      if (bus.wr_en && bus.wr_addr == 3'd5 && bus.wr_data[0]) load_req <= 1'b1;

      // Sticky flags: a set in the same cycle as a clear wins.
      if (bus.wr_en && bus.wr_addr == 3'd6) begin
        err_flag <= 1'b0;
        overrun  <= 1'b0;
      end
      if (capture_err) err_flag <= 1'b1;

      // Sample buffer: pop first, then a same-cycle write refills the slot.
      if (pop) begin
        sample_data <= pend_data;
        pend_full   <= 1'b0;
      end
      if (direct) begin
        sample_data <= bus.wr_data;
      end else if (samp_wr) begin
        if (!pend_full || pop) begin
          pend_data <= bus.wr_data;
          pend_full <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      // dr hold length tracking
      if (state == S_DR) dr_cnt <= dr_cnt + 2'd1;
      else               dr_cnt <= 2'd0;
      if (state == S_DR && dr_cnt == 2'd0) dr_ext <= err;

      // Coefficient sequencing: the value is latched on entry to LC_PULSE
      // and held until the next entry.
      if (load_go) begin
        idx       <= 2'd0;
        fir_coeff <= coef[0];
      end else if (advance) begin
        idx       <= idx + 2'd1;
        fir_coeff <= coef[idx + 2'd1];
      end

      // Result capture beats a same-cycle read clear.
      if (capture_ok) begin
        result       <= fir_out;
        result_valid <= 1'b1;
      end else if (bus.rd_en && bus.rd_addr == 3'd0) begin
        result_valid <= 1'b0;
      end

      if (bus.rd_en) bus.rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_fir_host_if.sv
// Directed testbench for fir_host_if with a small registered FIR core model.
module tb_fir_host_if;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  fir_host_if_if bus ();

  logic        modwait;
  logic        err;
  logic [15:0] fir_out;
  logic        dr;
  logic        lc;
  logic [15:0] sample_data;
  logic [15:0] fir_coeff;
  logic        result_valid;
  logic [2:0]  state_dbg;

  fir_host_if dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .bus          (bus),
    .modwait      (modwait),
    .err          (err),
    .fir_out      (fir_out),
    .dr           (dr),
    .lc           (lc),
    .sample_data  (sample_data),
    .fir_coeff    (fir_coeff),
    .result_valid (result_valid),
    .state_dbg    (state_dbg)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // ---------------- core model ----------------
  // Registered modwait: high from the cycle after lc for one cycle, or from
  // the cycle after the last dr cycle for calc_len cycles.
  int calc_len = 14;
  int mw_cnt   = 0;
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      modwait <= 1'b0;
      mw_cnt  <= 0;
    end else if (dr || lc) begin
      modwait <= 1'b1;
      mw_cnt  <= dr ? calc_len - 1 : 0;
    end else if (mw_cnt != 0) begin
      mw_cnt <= mw_cnt - 1;
    end else begin
      modwait <= 1'b0;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [15:0] coef_exp_q[$];
  logic [15:0] samp_exp_q[$];
  int   cyc = 0;
  int   dr_run = 0;
  int   dr_len_exp = 2;
  int   dr_rises = 0;
  int   lc_total = 0;
  int   lc_seen = 0;
  int   last_lc_cyc = 0;
  logic dr_prev = 1'b0;

  always @(negedge clk) begin
    logic [15:0] e;
    cyc++;
    if (dr === 1'b1) begin
      if (!dr_prev) begin
        dr_rises++;
        e = (samp_exp_q.size() > 0) ? samp_exp_q.pop_front() : 16'hDEAD;
        check("sample_data_at_dr", sample_data, e);
      end
      dr_run++;
    end else if (dr_prev) begin
      check("dr_len", 16'(dr_run), 16'(dr_len_exp));
      dr_run = 0;
    end
    dr_prev = (dr === 1'b1);
    if (lc === 1'b1) begin
      lc_total++;
      if (lc_seen > 0) check("lc_spacing", 16'(cyc - last_lc_cyc), 16'd3);
      lc_seen++;
      last_lc_cyc = cyc;
      e = (coef_exp_q.size() > 0) ? coef_exp_q.pop_front() : 16'hDEAD;
      check("fir_coeff_at_lc", fir_coeff, e);
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks are entered and left on a falling edge.
  task automatic host_write(input logic [2:0] a, input logic [15:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic host_read(input logic [2:0] a, output logic [15:0] d);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    @(negedge clk);
    bus.rd_en   = 1'b0;
    d = bus.rd_data;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max);
    int n = 0;
    while (state_dbg !== s && n < max) begin
      @(negedge clk);
      n++;
    end
    check("wait_state", 16'(state_dbg), 16'(s));
  endtask

  task automatic wait_idle(input int max);
    repeat (2) @(negedge clk);
    wait_state(3'd0, max);
  endtask

  task automatic wait_result(input int max);
    int n = 0;
    while (result_valid !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    check("result_valid_wait", 16'(result_valid), 16'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] d;
    int r0, l0;
    bus.wr_en = 1'b0; bus.wr_addr = 3'd0; bus.wr_data = 16'h0000;
    bus.rd_en = 1'b0; bus.rd_addr = 3'd0;
    err = 1'b0;
    fir_out = 16'h0000;
    n_reset = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);

    // Reset state: all reads zero, handshakes idle
    for (int a = 0; a < 8; a++) begin
      host_read(a[2:0], d);
      check($sformatf("rd_reset_a%0d", a), d, 16'h0000);
    end
    check("dr_reset", 16'(dr), 16'd0);
    check("lc_reset", 16'(lc), 16'd0);
    check("rv_reset", 16'(result_valid), 16'd0);
    check("coeff_reset", fir_coeff, 16'h0000);

    // Coefficient load sequence
    host_write(3'd1, 16'h0002);
    host_write(3'd2, 16'h0003);
    host_write(3'd3, 16'h0004);
    host_write(3'd4, 16'h0005);
    coef_exp_q = '{16'h0002, 16'h0003, 16'h0004, 16'h0005};
    lc_seen = 0;
    host_write(3'd5, 16'h0001);
    wait_idle(40);
    check("lc_count", 16'(lc_seen), 16'd4);
    check("coef_q_left", 16'(coef_exp_q.size()), 16'd0);
    for (int a = 0; a < 4; a++) begin
      host_read(3'(a + 2), d);
      check($sformatf("coef_rd%0d", a), d, 16'(a + 2));
    end

    // Single sample, 14-cycle computation
    fir_out = 16'h1234;
    dr_len_exp = 2;
    r0 = dr_rises;
    samp_exp_q.push_back(16'h0010);
    host_write(3'd0, 16'h0010);
    wait_result(40);
    host_read(3'd0, d);
    check("result_1234", d, 16'h1234);
    check("rv_after_read", 16'(result_valid), 16'd0);
    check("dr_count_single", 16'(dr_rises - r0), 16'd1);

    // Three back-to-back samples: one active, one pending, one dropped
    fir_out = 16'h1111;
    samp_exp_q.push_back(16'h00A1);
    samp_exp_q.push_back(16'h00A2);
    host_write(3'd0, 16'h00A1);
    host_write(3'd0, 16'h00A2);
    host_write(3'd0, 16'h00A3);
    host_read(3'd1, d);
    check("status_overrun", d, 16'h0011);
    wait_result(40);
    host_read(3'd0, d);
    check("result_first", d, 16'h1111);
    fir_out = 16'h2222;
    wait_result(40);
    host_read(3'd0, d);
    check("result_second", d, 16'h2222);
    repeat (3) @(negedge clk);
    check("samp_q_left", 16'(samp_exp_q.size()), 16'd0);
    host_write(3'd6, 16'h0000);
    host_read(3'd1, d);
    check("status_cleared", d, 16'h0000);

    // Core completes with err=1
    fir_out = 16'h5555;
    samp_exp_q.push_back(16'h0020);
    host_write(3'd0, 16'h0020);
    wait_state(3'd2, 10);
    err = 1'b1;
    wait_state(3'd0, 40);
    host_read(3'd1, d);
    check("status_err", d, 16'h0004);
    host_read(3'd0, d);
    check("result_unchanged", d, 16'h2222);
    check("rv_after_err", 16'(result_valid), 16'd0);

    // Next sample while err is still high: 3-cycle dr
    fir_out = 16'h6666;
    dr_len_exp = 3;
    samp_exp_q.push_back(16'h0030);
    host_write(3'd0, 16'h0030);
    @(negedge clk);
    err = 1'b0;
    wait_result(60);
    dr_len_exp = 2;
    host_read(3'd0, d);
    check("result_after_err", d, 16'h6666);
    host_read(3'd1, d);
    check("status_err_kept", d, 16'h0004);
    host_write(3'd6, 16'h0000);
    host_read(3'd1, d);
    check("status_err_clr", d, 16'h0000);

    // Reset during CALC
    fir_out = 16'h7777;
    samp_exp_q.push_back(16'h0040);
    host_write(3'd0, 16'h0040);
    wait_result(40);
    host_read(3'd2, d);
    check("rd_coef0_prereset", d, 16'h0002);
    samp_exp_q.push_back(16'h0050);
    host_write(3'd0, 16'h0050);
    wait_state(3'd2, 10);
    repeat (2) @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    check("rst_calc_dr", 16'(dr), 16'd0);
    check("rst_calc_lc", 16'(lc), 16'd0);
    check("rst_calc_rv", 16'(result_valid), 16'd0);
    check("rst_calc_sample", sample_data, 16'h0000);
    check("rst_calc_coeff", fir_coeff, 16'h0000);
    check("rst_calc_rd_data", bus.rd_data, 16'h0000);
    check("rst_calc_state", 16'(state_dbg), 16'd0);
    @(negedge clk);
    n_reset = 1'b1;
    samp_exp_q.delete();
    r0 = dr_rises;
    l0 = lc_total;
    host_read(3'd1, d);
    check("rst_calc_status", d, 16'h0000);
    host_read(3'd0, d);
    check("rst_calc_result", d, 16'h0000);
    host_read(3'd2, d);
    check("rst_calc_coef0", d, 16'h0000);
    repeat (20) @(negedge clk);
    check("rst_calc_no_dr", 16'(dr_rises), 16'(r0));
    check("rst_calc_no_lc", 16'(lc_total), 16'(l0));

    // Reset during LC_BUSY
    host_write(3'd1, 16'h0007);
    host_write(3'd2, 16'h0008);
    host_write(3'd3, 16'h0009);
    host_write(3'd4, 16'h000A);
    coef_exp_q = '{16'h0007};
    lc_seen = 0;
    host_write(3'd5, 16'h0001);
    wait_state(3'd4, 10);
    #2 n_reset = 1'b0;
    #1;
    check("rst_lc_lc", 16'(lc), 16'd0);
    check("rst_lc_coeff", fir_coeff, 16'h0000);
    check("rst_lc_state", 16'(state_dbg), 16'd0);
    @(negedge clk);
    n_reset = 1'b1;
    check("rst_lc_q_left", 16'(coef_exp_q.size()), 16'd0);
    r0 = dr_rises;
    l0 = lc_total;
    host_read(3'd1, d);
    check("rst_lc_status", d, 16'h0000);
    host_read(3'd3, d);
    check("rst_lc_coef1", d, 16'h0000);
    repeat (20) @(negedge clk);
    check("rst_lc_no_lc", 16'(lc_total), 16'(l0));
    check("rst_lc_no_dr", 16'(dr_rises), 16'(r0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_host_if.md
# fir_host_if

Host-side front end for the FIR filter core. It turns simple register writes and reads into the core's handshake: `dr` for data ready and `lc` for load coefficient, with `modwait` and `err` coming back. It buffers one pending sample, sequences the four coefficient loads in order, and captures each filtered result. It sits between the system bus and the FIR controller/datapath pair, and drives `sample_data` and `fir_coeff` into the datapath.

## Interface
- No parameters. All data is 16 bits wide. Register addresses are 3 bits wide.
- clk  in  1  system clock, rising edge
- n_reset  in  1  reset, asynchronous, active-low
- wr_en  in  1  host write strobe, one cycle
- wr_addr  in  3  write address
- wr_data  in  16  write data
- rd_en  in  1  host read strobe, one cycle
- rd_addr  in  3  read address
- rd_data  out  16  read data, registered
- modwait  in  1  core busy, from the FIR controller
- err  in  1  core error/overflow, from the FIR controller
- fir_out  in  16  datapath result register
- dr  out  1  data ready to the core
- lc  out  1  load coefficient to the core
- sample_data  out  16  sample presented to the datapath
- fir_coeff  out  16  coefficient presented to the datapath
- result_valid  out  1  unread result present (interrupt level)

## Operation
- Write map:
  - addr 0: sample.
  - addr 1..4: coefficients F0..F3 (`coef[0..3]`).
  - addr 5: a write with `wr_data[0]=1` sets `load_req`.
  - addr 6: a write of any value clears `err_flag` and `overrun`.
  - addr 7: ignored.
- Read map:
  - addr 0: result. A read also clears `result_valid`.
  - addr 1: status = {11'b0, overrun, load_req|loading, err_flag, result_valid, busy}.
  - addr 2..5: `coef[0..3]`.
  - addr 6..7: read as 0.
- Sample buffer: one active register (`sample_data`) plus one pending slot.
  - Sample write while the FSM is IDLE and the pending slot is empty: the value goes to `sample_data` and the FSM starts DR.
  - Sample write while busy and the slot is empty: the value goes to the pending slot.
  - Sample write while the slot is full: the write is dropped and `overrun` is set (sticky).
- FSM states: IDLE, DR, CALC, LC_PULSE, LC_BUSY.
- IDLE priority:
  1. `load_req` and `err`=0: go to LC_PULSE with index 0, and clear `load_req`.
  2. Pending sample: move it into `sample_data` and go to DR.
  3. Otherwise stay in IDLE.
- DR: `dr`=1.
  - Hold length is 2 cycles. It is 3 cycles if `err`=1 in the first DR cycle, because the core needs the extra cycle to leave its error idle state.
  - Then go to CALC.
- CALC: `dr`=0. Wait for the first cycle with `modwait`=0. In that cycle:
  - If `err`=0: `result` <= `fir_out` and set `result_valid`.
  - If `err`=1: set `err_flag` (sticky) and leave `result` unchanged.
  - Then go to IDLE.
- LC_PULSE: `lc`=1 for one cycle, then go to LC_BUSY.
- LC_BUSY: `lc`=0. On the first cycle with `modwait`=0:
  - If index=3: go to IDLE.
  - Otherwise increment the index and go to LC_PULSE.
- `fir_coeff` = `coef[index]`. It is held stable throughout LC_PULSE and LC_BUSY.
- `busy` = (state ≠ IDLE) or pending slot full.
- Coefficient writes during loading take effect in `coef[]` immediately. The value for the current index is the one latched on entry to LC_PULSE.
- A load request while `err`=1 stays pending until `err` falls. `err` only falls after a sample has been processed.

## Timing
- Reset values: `dr`, `lc`, `result_valid`, `rd_data`, `sample_data`, `fir_coeff` and `result` = 0. `coef[]` = 0, pending slot empty, `err_flag` = 0, `overrun` = 0, `load_req` = 0, index = 0, state IDLE.
- Reset mid-operation drops all in-flight work immediately. No further `dr`/`lc` is issued.
- Sample write in cycle t with the FSM in IDLE and the slot empty: `sample_data` valid from t+1, `dr` high in t+1 and t+2.
- Coefficient load: 3 cycles per coefficient against a responsive core, so 12 cycles from LC_PULSE 0 to IDLE.
- `rd_data` is valid in the cycle after `rd_en`.
- A read of addr 0 in the same cycle a new result is captured: the capture wins and `result_valid` stays 1.
- Sample write and pending-slot pop in the same cycle: the pop is taken first, then the new write goes into the slot.
- Status reflects values at the edge before the read.

## Test plan
- Reset, then read all addresses: every read returns 0, `dr`=`lc`=0, `result_valid`=0.
- Write `coef` 1..4 = 0x0002, 0x0003, 0x0004, 0x0005, then write addr 5 = 1:
  - `lc` pulses 4 times, 3 cycles apart.
  - `fir_coeff` is 0x0002, 0x0003, 0x0004, 0x0005 in order.
  - Core model shows `modwait` high for 1 cycle per coefficient.
- Write sample 0x0010; core model holds `modwait` for 14 cycles then returns `fir_out`=0x1234:
  - `dr` is high for exactly 2 cycles.
  - `result_valid`=1; a read of addr 0 returns 0x1234 and `result_valid` drops.
- Write three samples back-to-back during a computation:
  - The first is processed and the second is held pending, then processed.
  - The third is dropped; status reads 0x0011 (`overrun` and `busy` set).
- Core completes with `err`=1:
  - `err_flag` is set and `result` is unchanged.
  - The next sample gives a 3-cycle `dr`.
  - Writing addr 6 clears the flag; status bit 2 reads 0.
- Assert `n_reset` during CALC and during LC_BUSY: all outputs and status return to 0 within the reset cycle, and no `dr`/`lc` is issued after release.
